// File: rtl/bias_add_relu_stage.sv
// -----------------------------------------------------------------------------
// bias_add_relu_stage
//
// Output stage that sits after the adder tree of a SqueezeNext layer. Each
// accepted vector holds N_adder_tree signed accumulator lanes. For every lane
// the stage adds the matching 18-bit bias word and saturates the sum to OUT_W.
// If RELU is set, negative results are then clamped to zero. The stage is a
// two-register valid/ready pipeline (add, then saturate/activate) with full
// backpressure. A vector counter tags each vector so the output can mark the
// last vector of every feature map.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bias_in     packed 18-bit signed biases, lane i at [18*i +: 18] (static)
//   acc_in      packed ACC_W-bit signed accumulators, lane i at [ACC_W*i +: ACC_W]
//   in_valid    acc_in holds a vector
//   in_ready    stage can take a vector this cycle
//   out_data    packed OUT_W-bit results, same lane order as acc_in
//   out_valid   out_data holds a vector
//   out_ready   downstream takes out_data this cycle
//   out_last    the vector on out_data is number FRAME_LEN-1 of its frame
//   frame_done  one-cycle pulse, the cycle after the last vector of a frame
//               leaves the stage
// -----------------------------------------------------------------------------
module bias_add_relu_stage #(
    parameter int N_adder_tree = 16,
    parameter int ACC_W        = 18,
    parameter int OUT_W        = 18,
    parameter int RELU         = 1,
    parameter int FRAME_LEN    = 196
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_adder_tree*18-1:0]    bias_in,
    input  logic [N_adder_tree*ACC_W-1:0] acc_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [N_adder_tree*OUT_W-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          frame_done
);

    localparam int BIAS_W = 18;
    // One guard bit above the accumulator width, so acc + bias cannot overflow.
    localparam int SUM_W  = ACC_W + 1;
    localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [CNT_W-1:0] LAST_TAG = CNT_W'(FRAME_LEN - 1);

    // Saturation limits for OUT_W, expressed at the sum width so the compare
    // is a plain signed compare.
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // ---------------------------------------------------------------------
    // Pipeline control
    // ---------------------------------------------------------------------
    logic             r_s1_valid;
    logic [CNT_W-1:0] r_s1_tag;
    logic             r_s2_valid;
    logic             r_s2_last;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_vcnt;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic             w_xfer;
    logic             w_s2_load;
    logic [CNT_W-1:0] w_vcnt_next;

    // A stage may take new data when it is empty or its contents move on in
    // the same cycle. in_ready depends on out_ready and the valid flags only,
    // never on in_valid.
    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_accept  = in_valid && w_s1_adv;
    assign w_xfer    = r_s2_valid && out_ready;
    // Lane data in stage 2 changes only when a real vector moves in. After a
    // bubble, out_data keeps the last result instead of showing junk.
    assign w_s2_load = w_s2_adv && r_s1_valid;

    assign w_vcnt_next = (r_vcnt == LAST_TAG) ? '0 : r_vcnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_tag     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_last    <= 1'b0;
            r_frame_done <= 1'b0;
            r_vcnt       <= '0;
        end else begin
            // Stage 1: take a new vector, or empty out when its vector has
            // moved on to stage 2.
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_tag   <= r_vcnt;
                r_vcnt     <= w_vcnt_next;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            // Stage 2: out_last is valid only together with a real vector.
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                r_s2_last  <= r_s1_valid && (r_s1_tag == LAST_TAG);
            end

            // The pulse appears in the cycle after the last vector is taken.
            r_frame_done <= w_xfer && r_s2_last;
        end
    end

    assign in_ready   = w_s1_adv;
    assign out_valid  = r_s2_valid;
    assign out_last   = r_s2_last;
    assign frame_done = r_frame_done;

    // ---------------------------------------------------------------------
    // Per-lane datapath: bias add (stage 1), saturate and ReLU (stage 2)
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_adder_tree; gi++) begin : g_lane
            logic        [ACC_W-1:0]  w_acc;
            logic        [BIAS_W-1:0] w_bias;
            logic signed [SUM_W-1:0]  w_sum;
            logic signed [SUM_W-1:0]  r_sum;
            logic        [OUT_W-1:0]  w_sat;
            logic        [OUT_W-1:0]  r_out;

            assign w_acc  = acc_in[ACC_W*gi +: ACC_W];
            assign w_bias = bias_in[BIAS_W*gi +: BIAS_W];

            // Sign-extend both operands to the sum width before adding.
            assign w_sum = {{(SUM_W-ACC_W){w_acc[ACC_W-1]}}, w_acc}
                         + {{(SUM_W-BIAS_W){w_bias[BIAS_W-1]}}, w_bias};

            always_comb begin
                w_sat = r_sum[OUT_W-1:0];
                if (r_sum > SAT_MAX) begin
                    w_sat = SAT_MAX[OUT_W-1:0];
                end else if (r_sum < SAT_MIN) begin
                    w_sat = SAT_MIN[OUT_W-1:0];
                end
                // ReLU is applied after saturation, so a saturated negative
                // value also goes to zero.
                if ((RELU != 0) && w_sat[OUT_W-1]) begin
                    w_sat = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum <= '0;
                    r_out <= '0;
                end else begin
                    if (w_accept) begin
                        r_sum <= w_sum;
                    end
                    if (w_s2_load) begin
                        r_out <= w_sat;
                    end
                end
            end

            assign out_data[OUT_W*gi +: OUT_W] = r_out;
        end
    endgenerate

endmodule
